// File: rtl/sm_mdu_pkg.sv
// Shared definitions for the schoolMIPS multiply/divide unit: op codes, FSM states,
// decode function codes and small op-classification helpers.
package sm_mdu_pkg;

    localparam int unsigned MDU_OP_W = 3;
    localparam int unsigned FUNCT_W  = 6;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_SIGN = 2'd2
    } mdu_state_e;

    // R-type funct field values decoded by sm_control
    localparam logic [FUNCT_W-1:0] F_MFHI  = 6'h10;
    localparam logic [FUNCT_W-1:0] F_MTHI  = 6'h11;
    localparam logic [FUNCT_W-1:0] F_MFLO  = 6'h12;
    localparam logic [FUNCT_W-1:0] F_MTLO  = 6'h13;
    localparam logic [FUNCT_W-1:0] F_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] F_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] F_DIV   = 6'h1a;
    localparam logic [FUNCT_W-1:0] F_DIVU  = 6'h1b;

    // Per-operation attributes latched at launch and used in the sign-fix step
    typedef struct packed {
        logic is_div;
        logic neg_quo;
        logic neg_rem;
    } mdu_job_t;

    function automatic logic mdu_is_signed(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic mdu_is_div(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/sm_mdu_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
module sm_mdu_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    assign out = en ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/sm_mdu.sv
// Iterative multiply/divide unit with HI/LO registers: one product/quotient bit per cycle,
// magnitudes computed up front and the sign applied in a final SIGN cycle.
module sm_mdu
    import sm_mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    mdu_state_e       state_q, state_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] src_a_q, src_a_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    mdu_job_t         job_q, job_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [DW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial, div_diff;
    logic [DW-1:0]    step;

    assign sign_a = mdu_is_signed(op) & srcA[WIDTH-1];
    assign sign_b = mdu_is_signed(op) & srcB[WIDTH-1];

    sm_mdu_neg #(.WIDTH(WIDTH)) u_abs_a (.en(sign_a), .in(srcA), .out(abs_a));
    sm_mdu_neg #(.WIDTH(WIDTH)) u_abs_b (.en(sign_b), .in(srcB), .out(abs_b));

    sm_mdu_neg #(.WIDTH(DW)) u_fix_prod (
        .en  (job_q.neg_quo),
        .in  (acc_q),
        .out (prod_fix)
    );
    sm_mdu_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .en  (job_q.neg_quo),
        .in  (acc_q[WIDTH-1:0]),
        .out (quo_fix)
    );
    sm_mdu_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .en  (job_q.neg_rem),
        .in  (acc_q[DW-1:WIDTH]),
        .out (rem_fix)
    );

    // One iteration: acc = {partial product, multiplier} or {remainder, quotient/dividend}
    always_comb begin
        mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd_q};
        if (!job_q.is_div) begin
            step = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        src_a_d    = src_a_q;
        cnt_d      = cnt_q;
        job_d      = job_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            job_d.is_div  = mdu_is_div(op);
                            job_d.neg_quo = sign_a ^ sign_b;
                            job_d.neg_rem = sign_a;
                            // Divide walks the dividend; multiply walks the multiplier
                            opnd_d  = mdu_is_div(op) ? abs_b : abs_a;
                            acc_d   = {{WIDTH{1'b0}}, (mdu_is_div(op) ? abs_a : abs_b)};
                            src_a_d = srcA;
                            cnt_d   = '0;
                            state_d = MDU_CALC;
                        end
                        MDU_MTHI: begin
                            hi_d   = srcA;
                            done_d = 1'b1;
                        end
                        MDU_MTLO: begin
                            lo_d   = srcA;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            MDU_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = MDU_SIGN;
                end
            end
            MDU_SIGN: begin
                if (!job_q.is_div) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (opnd_q == '0) begin
                    lo_d       = '1;
                    hi_d       = src_a_q;
                    div_zero_d = 1'b1;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
                done_d  = 1'b1;
                state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase

        busy_d = (state_d != MDU_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= MDU_IDLE;
            acc_q      <= '0;
            opnd_q     <= '0;
            src_a_q    <= '0;
            cnt_q      <= '0;
            job_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            src_a_q    <= src_a_d;
            cnt_q      <= cnt_d;
            job_q      <= job_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign divZero = div_zero_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_sm_mdu.sv
// Directed and random checks of sm_mdu against a behavioural multiply/divide model
// through an expected-result queue.
module tb_sm_mdu;
    import sm_mdu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         busy;
    logic         done;
    logic         divZero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    res_t         sb[$];
    int           n_checks;
    int           n_err;
    logic [W-1:0] cur_hi;
    logic [W-1:0] cur_lo;

    sm_mdu #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .busy    (busy),
        .done    (done),
        .divZero (divZero),
        .hi      (hi),
        .lo      (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t mk(input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
        res_t r;
        r.hi = h;
        r.lo = l;
        r.dz = d;
        return r;
    endfunction

    // Behavioural reference using native 64-bit arithmetic
    function automatic res_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t              r;
        logic signed [63:0] sa, sbv, q, rm;
        logic [63:0]        p;
        sa  = {{32{a[W-1]}}, a};
        sbv = {{32{b[W-1]}}, b};
        r   = mk(cur_hi, cur_lo, 1'b0);
        case (o)
            3'd0: begin p = sa * sbv; r.hi = p[63:32]; r.lo = p[31:0]; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == '0) begin
                    r = mk(a, '1, 1'b1);
                end else if (o == 3'd2) begin
                    q = sa / sbv; rm = sa % sbv;
                    r.lo = q[31:0]; r.hi = rm[31:0];
                end else begin
                    r.lo = a / b; r.hi = a % b;
                end
            end
            3'd4: r.hi = a;
            3'd5: r.lo = a;
            default: ;
        endcase
        return r;
    endfunction

    // Launch at a negedge, wait for done, check latency/busy profile and popped result
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input res_t exp);
        int   lat;
        int   nb;
        bit   arith;
        res_t e;
        arith = (o <= 3'd3);
        sb.push_back(exp);
        start = 1'b1; op = o; srcA = a; srcB = b;
        lat = 0; nb = 0;
        while (1) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done === 1'b1) break;
            if (busy === 1'b1) nb++;
            if (lat > 80) break;
        end
        chk($sformatf("latency op%0d", o), 64'(lat), arith ? 64'(W + 2) : 64'd1);
        chk($sformatf("busy_cycles op%0d", o), 64'(nb), arith ? 64'(W + 1) : 64'd0);
        chk("busy_at_done", 64'(busy), 64'd0);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("hi op%0d a=%0h b=%0h", o, a, b), 64'(hi), 64'(e.hi));
            chk($sformatf("lo op%0d a=%0h b=%0h", o, a, b), 64'(lo), 64'(e.lo));
            chk($sformatf("divZero op%0d", o), 64'(divZero), 64'(e.dz));
            cur_hi = e.hi;
            cur_lo = e.lo;
        end
        @(negedge clk);
        chk("done_pulse_width", 64'(done), 64'd0);
        chk("divZero_pulse_width", 64'(divZero), 64'd0);
    endtask

    initial begin
        int   lat;
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;

        n_checks = 0; n_err = 0;
        cur_hi = '0; cur_lo = '0;
        rst_n = 1'b0; start = 1'b0; op = '0; srcA = '0; srcB = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset divZero", 64'(divZero), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
        do_op(3'd0, 32'hFFFF_FFFD, 32'd5,         mk(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0));
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0,         32'h8000_0000, 1'b0));
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2,         mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
        do_op(3'd3, 32'd7,         32'd2,         mk(32'd1,         32'd3,         1'b0));
        do_op(3'd2, 32'd7,         32'hFFFF_FFFE, mk(32'd1,         32'hFFFF_FFFD, 1'b0));
        do_op(3'd5, 32'hCAFE_F00D, 32'h0,         mk(cur_hi,        32'hCAFE_F00D, 1'b0));
        do_op(3'd3, 32'h1234_5678, 32'h0,         mk(32'h1234_5678, 32'hFFFF_FFFF, 1'b1));

        // MULTU 6x7 with an MTHI issued while busy, then MTHI in the done cycle
        start = 1'b1; op = 3'd1; srcA = 32'd6; srcB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd4; srcA = 32'hA5A5_A5A5;
        chk("hold hi during calc", 64'(hi), 64'(cur_hi));
        @(negedge clk);
        start = 1'b0;
        chk("busy ignores start", 64'(busy), 64'd1);
        chk("hi ignores busy MTHI", 64'(hi), 64'(cur_hi));
        lat = 6;
        while (done !== 1'b1 && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        chk("seq latency", 64'(lat), 64'(W + 2));
        chk("seq hi 6x7", 64'(hi), 64'd0);
        chk("seq lo 6x7", 64'(lo), 64'd42);
        start = 1'b1; op = 3'd4; srcA = 32'hA5A5_A5A5;
        @(negedge clk);
        start = 1'b0;
        chk("mthi done", 64'(done), 64'd1);
        chk("mthi hi", 64'(hi), 64'hA5A5_A5A5);
        chk("mthi lo kept", 64'(lo), 64'd42);
        chk("mthi busy", 64'(busy), 64'd0);
        @(negedge clk);
        cur_hi = 32'hA5A5_A5A5; cur_lo = 32'd42;

        // Reset in the middle of a divide
        start = 1'b1; op = 3'd2; srcA = 32'd1000; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy before reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        chk("midreset divZero", 64'(divZero), 64'd0);
        chk("midreset hi", 64'(hi), 64'd0);
        chk("midreset lo", 64'(lo), 64'd0);
        cur_hi = '0; cur_lo = '0;
        @(negedge clk);
        do_op(3'd3, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0));

        for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'($urandom_range(0, 3)) : $urandom;
            do_op(ro, ra, rb, model(ro, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
